// File: rtl/regfile_seq.sv
// regfile_seq: sequencer driving ordered select/strobe pulses into the 8085 register file.
// Ports: clk/rst, op_* request handshake, pair selects, rd/wr strobes, dreg inc/dec
// controls, DATA drive (data_out/data_oe), captured rd_data/carry_flag, done/err.
module regfile_seq #(
  parameter int STROBE_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [2:0] op_code,
  input  logic [2:0] pair_sel,
  input  logic       cnt2,
  input  logic [7:0] wr_data,
  input  logic [7:0] data_in,
  input  logic       carry_in,
  output logic       bc_rw,
  output logic       de_rw,
  output logic       hl_rw,
  output logic       wz_rw,
  output logic       pc_rw,
  output logic       sp_rw,
  output logic       rreg_rd,
  output logic       lreg_rd,
  output logic       rreg_wr,
  output logic       lreg_wr,
  output logic       dreg_rd,
  output logic       dreg_wr,
  output logic       dreg_inc,
  output logic       dreg_dec,
  output logic       dreg_cnt,
  output logic       dreg_cnt2,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [7:0] rd_data,
  output logic       carry_flag,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STRB, S_HOLD,
    S_STRB2, S_HOLD2, S_DONE
  } state_t;

  localparam logic [3:0] CNT_LD = 4'(STROBE_W - 1);

  state_t     r_state, w_nstate;
  logic [3:0] r_cnt, w_ncnt;
  logic [2:0] r_code, r_pair;
  logic       r_cnt2;
  logic [7:0] r_wr;

  logic       w_acc;
  logic [2:0] w_code, w_pair;
  logic       w_c2;
  logic [7:0] w_wr;
  logic       w_ill, w_isrd, w_iswr, w_isid;
  logic       w_last, w_busy, w_oe, w_ctl;
  logic [5:0] w_sel, w_stb;

  assign w_acc  = op_valid && (r_state == S_IDLE);
  // Output decode runs off next state, so the op fields
  // must come straight from the inputs on the accept edge.
  assign w_code = w_acc ? op_code  : r_code;
  assign w_pair = w_acc ? pair_sel : r_pair;
  assign w_c2   = w_acc ? cnt2     : r_cnt2;
  assign w_wr   = w_acc ? wr_data  : r_wr;

  assign w_ill  = (w_code != 3'd0) && (w_pair > 3'd5);
  assign w_isrd = (w_code == 3'd1) || (w_code == 3'd2);
  assign w_iswr = (w_code == 3'd3) || (w_code == 3'd4);
  assign w_isid = (w_code == 3'd6) || (w_code == 3'd7);
  assign w_last = (r_cnt == 4'd0);

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    unique case (r_state)
      S_IDLE:
        if (w_acc)
          w_nstate = (op_code == 3'd0 || w_ill) ? S_DONE : S_SETUP;
      S_SETUP: begin
        w_nstate = S_STRB;
        w_ncnt   = CNT_LD;
      end
      S_STRB:
        if (w_last) w_nstate = S_HOLD;
        else        w_ncnt   = r_cnt - 4'd1;
      S_HOLD:
        if (w_isid) begin
          w_nstate = S_STRB2;
          w_ncnt   = CNT_LD;
        end else begin
          w_nstate = S_DONE;
        end
      S_STRB2:
        if (w_last) w_nstate = S_HOLD2;
        else        w_ncnt   = r_cnt - 4'd1;
      S_HOLD2: w_nstate = S_DONE;
      S_DONE:  w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  assign w_busy = (w_nstate != S_IDLE) && (w_nstate != S_DONE);
  assign w_sel  = w_busy ? (6'd1 << w_pair) : 6'd0;
  assign w_oe   = w_iswr && ((w_nstate == S_SETUP) ||
                  (w_nstate == S_STRB) || (w_nstate == S_HOLD));
  assign w_ctl  = w_isid && w_busy;

  // Strobe vector: {dreg_wr,dreg_rd,lreg_wr,rreg_wr,lreg_rd,rreg_rd}
  always_comb begin
    w_stb = 6'd0;
    if (w_nstate == S_STRB) begin
      unique case (1'b1)
        (w_code == 3'd1): w_stb = 6'b000001;
        (w_code == 3'd2): w_stb = 6'b000010;
        (w_code == 3'd3): w_stb = 6'b000100;
        (w_code == 3'd4): w_stb = 6'b001000;
        (w_code >= 3'd5): w_stb = 6'b010000;
        default:          w_stb = 6'd0;
      endcase
    end else if (w_nstate == S_STRB2) begin
      w_stb = 6'b100000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_code     <= 3'd0;
      r_pair     <= 3'd0;
      r_cnt2     <= 1'b0;
      r_wr       <= 8'h00;
      op_ready   <= 1'b1;
      {sp_rw, pc_rw, wz_rw, hl_rw, de_rw, bc_rw} <= 6'd0;
      {dreg_wr, dreg_rd, lreg_wr, rreg_wr, lreg_rd, rreg_rd} <= 6'd0;
      dreg_inc   <= 1'b0;
      dreg_dec   <= 1'b0;
      dreg_cnt   <= 1'b0;
      dreg_cnt2  <= 1'b0;
      data_out   <= 8'h00;
      data_oe    <= 1'b0;
      rd_data    <= 8'h00;
      carry_flag <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_cnt    <= w_ncnt;
      if (w_acc) begin
        r_code <= op_code;
        r_pair <= pair_sel;
        r_cnt2 <= cnt2;
        r_wr   <= wr_data;
      end
      op_ready <= (w_nstate == S_IDLE);
      {sp_rw, pc_rw, wz_rw, hl_rw, de_rw, bc_rw} <= w_sel;
      {dreg_wr, dreg_rd, lreg_wr, rreg_wr, lreg_rd, rreg_rd} <= w_stb;
      dreg_inc  <= w_ctl && (w_code == 3'd6);
      dreg_dec  <= w_ctl && (w_code == 3'd7);
      dreg_cnt  <= w_ctl && !w_c2;
      dreg_cnt2 <= w_ctl && w_c2;
      data_out  <= w_oe ? w_wr : 8'h00;
      data_oe   <= w_oe;
      done      <= (w_nstate == S_DONE);
      err       <= (w_nstate == S_DONE) && w_ill;
      if ((r_state == S_STRB) && w_last && w_isrd)
        rd_data <= data_in;
      if ((r_state == S_HOLD) && w_isid)
        carry_flag <= carry_in;
    end
  end

endmodule

// File: tb/tb_regfile_seq.sv
// tb_regfile_seq: random + directed stimulus with a scoreboard for regfile_seq.
// Expected per-op timing/strobe counts come from an abstract op model.
module tb_regfile_seq;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic op_valid = 1'b0;
  logic [2:0] op_code = '0, pair_sel = '0;
  logic cnt2 = 1'b0, carry_in = 1'b0;
  logic [7:0] wr_data = '0, data_in = '0;
  logic op_ready;
  logic bc_rw, de_rw, hl_rw, wz_rw, pc_rw, sp_rw;
  logic rreg_rd, lreg_rd, rreg_wr, lreg_wr, dreg_rd, dreg_wr;
  logic dreg_inc, dreg_dec, dreg_cnt, dreg_cnt2;
  logic [7:0] data_out, rd_data;
  logic data_oe, carry_flag, done, err;

  regfile_seq #(.STROBE_W(W)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .pair_sel(pair_sel), .cnt2(cnt2),
    .wr_data(wr_data), .data_in(data_in), .carry_in(carry_in),
    .bc_rw(bc_rw), .de_rw(de_rw), .hl_rw(hl_rw), .wz_rw(wz_rw),
    .pc_rw(pc_rw), .sp_rw(sp_rw),
    .rreg_rd(rreg_rd), .lreg_rd(lreg_rd), .rreg_wr(rreg_wr),
    .lreg_wr(lreg_wr), .dreg_rd(dreg_rd), .dreg_wr(dreg_wr),
    .dreg_inc(dreg_inc), .dreg_dec(dreg_dec), .dreg_cnt(dreg_cnt),
    .dreg_cnt2(dreg_cnt2), .data_out(data_out), .data_oe(data_oe),
    .rd_data(rd_data), .carry_flag(carry_flag), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [5:0] stb, sel;
  logic [3:0] ctl;
  assign stb = {dreg_wr, dreg_rd, lreg_wr, rreg_wr, lreg_rd, rreg_rd};
  assign sel = {sp_rw, pc_rw, wz_rw, hl_rw, de_rw, bc_rw};
  assign ctl = {dreg_inc, dreg_dec, dreg_cnt, dreg_cnt2};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0] code;
    logic [2:0] pair;
    logic       c2;
    logic [7:0] wr;
    int         t0;
    int         lat;
    logic       err;
    logic [7:0] rd;
    logic       cy;
  } exp_t;

  exp_t q[$];
  logic [7:0] m_rd = '0;
  logic m_cy = 1'b0;

  // Abstract model: latency and captured values from the op rules.
  function automatic exp_t model(input logic [2:0] c, input logic [2:0] p,
                                 input logic c2, input logic [7:0] w,
                                 input logic [7:0] d, input logic ci);
    exp_t e;
    e.code = c; e.pair = p; e.c2 = c2; e.wr = w;
    e.err = (c != 0) && (p > 5);
    if (c == 0 || e.err) e.lat = 1;
    else if (c >= 6)     e.lat = 2 * W + 4;
    else                 e.lat = W + 3;
    if (!e.err && (c == 1 || c == 2)) m_rd = d;
    if (!e.err && c >= 6) m_cy = ci;
    e.rd = m_rd; e.cy = m_cy;
    e.t0 = cyc + 1;
    return e;
  endfunction

  task automatic issue(input logic [2:0] c, input logic [2:0] p,
                       input logic c2, input logic [7:0] w,
                       input logic [7:0] d, input logic ci);
    int n = 0;
    while (!op_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!op_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    op_code = c; pair_sel = p; cnt2 = c2; wr_data = w;
    data_in = d; carry_in = ci; op_valid = 1'b1;
    q.push_back(model(c, p, c2, w, d, ci));
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  // Monitor / scoreboard
  int n_s[6];
  int n_rise, n_sel, n_oe, n_oeok, n_ctl;
  logic [5:0] sel_or, p_stb, p_sel;
  logic [3:0] ctl_or;
  logic rdy_next;

  task automatic clr();
    for (int i = 0; i < 6; i++) n_s[i] = 0;
    n_rise = 0; n_sel = 0; n_oe = 0; n_oeok = 0; n_ctl = 0;
    sel_or = '0; ctl_or = '0;
  endtask

  initial begin
    exp_t e;
    logic legal, byt, idc;
    int ei;
    clr();
    p_stb = '0; p_sel = '0; rdy_next = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete(); clr();
        p_stb = '0; p_sel = '0; rdy_next = 1'b0;
      end else begin
        if (rdy_next) begin
          chk("ready_after_done", op_ready, 1);
          rdy_next = 1'b0;
        end
        if (stb != 0) begin
          chk("one_strobe", 32'($onehot(stb)), 1);
          chk("one_sel_in_strobe", 32'($onehot(sel)), 1);
        end
        if (stb != 0 && p_stb == 0)
          chk("sel_setup", 32'(sel != 0 && sel == p_sel), 1);
        if (stb == 0 && p_stb != 0)
          chk("sel_hold", 32'(sel != 0 && sel == p_sel), 1);
        for (int i = 0; i < 6; i++) begin
          n_s[i] += 32'(stb[i]);
          if (stb[i] && !p_stb[i]) n_rise++;
        end
        if (sel != 0) n_sel++;
        sel_or |= sel;
        if (ctl != 0) n_ctl++;
        ctl_or |= ctl;
        if (data_oe) begin
          n_oe++;
          if (q.size() > 0 && data_out == q[0].wr) n_oeok++;
        end
        if (done) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            legal = !e.err && e.code != 0;
            byt = legal && e.code <= 5;
            idc = legal && e.code >= 6;
            chk("latency", cyc - e.t0 + 1, e.lat);
            chk("err", err, e.err);
            chk("rd_data", rd_data, e.rd);
            chk("carry_flag", carry_flag, e.cy);
            chk("ready_in_done", op_ready, 0);
            chk("sel_cycles", n_sel, byt ? W + 2 : (idc ? 2 * W + 3 : 0));
            chk("sel_which", sel_or, (byt || idc) ? (6'd1 << e.pair) : 6'd0);
            ei = byt ? int'(e.code) - 1 : -1;
            for (int i = 0; i < 6; i++)
              chk($sformatf("strobe%0d_cycles", i), n_s[i],
                  (i == ei || (idc && i >= 4)) ? W : 0);
            chk("strobe_pulses", n_rise, byt ? 1 : (idc ? 2 : 0));
            chk("oe_cycles", n_oe,
                (legal && (e.code == 3 || e.code == 4)) ? W + 2 : 0);
            chk("oe_data", n_oeok, n_oe);
            chk("ctl_cycles", n_ctl, idc ? 2 * W + 3 : 0);
            chk("ctl_value", ctl_or,
                idc ? {e.code == 6, e.code == 7, !e.c2, e.c2} : 4'd0);
            rdy_next = 1'b1;
          end
          clr();
        end
        p_stb = stb; p_sel = sel;
      end
    end
  end

  initial begin
    int n;
    // Reset held with a pending request
    op_valid = 1'b1; op_code = 3'd3; pair_sel = 3'd1; wr_data = 8'hA5;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_outputs", {stb, sel, ctl, done, err, data_oe}, 0);
      chk("rst_ready", op_ready, 1);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_carry", carry_flag, 0);
    end
    rst = 1'b0; op_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_idle", {stb, sel, data_oe, done}, 0);
    end

    // Directed ops
    issue(3'd3, 3'd1, 1'b0, 8'h5A, 8'h00, 1'b0);
    issue(3'd2, 3'd2, 1'b0, 8'h00, 8'h3C, 1'b0);
    issue(3'd6, 3'd4, 1'b1, 8'h00, 8'h00, 1'b1);
    issue(3'd7, 3'd5, 1'b0, 8'h00, 8'h00, 1'b0);
    issue(3'd1, 3'd7, 1'b0, 8'h00, 8'h11, 1'b1);
    issue(3'd0, 3'd0, 1'b0, 8'h00, 8'h22, 1'b0);
    issue(3'd5, 3'd3, 1'b0, 8'h00, 8'h00, 1'b0);

    // Random ops
    repeat (150) begin
      logic [2:0] c, p;
      c = 3'($urandom_range(0, 7));
      p = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(6, 7))
                                      : 3'($urandom_range(0, 5));
      issue(c, p, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end

    // Mid-op reset: give rd_data and carry_flag nonzero values first
    issue(3'd1, 3'd0, 1'b0, 8'h00, 8'hC3, 1'b0);
    issue(3'd6, 3'd2, 1'b0, 8'h00, 8'h00, 1'b1);
    issue(3'd4, 3'd1, 1'b0, 8'h96, 8'h00, 1'b0);
    // now one cycle past E0 (SETUP); advance into second STRB cycle
    repeat (2) begin @(posedge clk); #1; end
    chk("midrst_pre_strobe", lreg_wr, 1);
    rst = 1'b1;
    op_code = 3'd1; pair_sel = 3'd3; data_in = 8'h7E; op_valid = 1'b1;
    m_rd = '0; m_cy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_lreg_wr", lreg_wr, 0);
    chk("midrst_data_oe", data_oe, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rd_data", rd_data, 0);
    chk("midrst_carry", carry_flag, 0);
    chk("midrst_ready", op_ready, 1);
    q.push_back(model(3'd1, 3'd3, 1'b0, 8'h00, 8'h7E, 1'b0));
    @(posedge clk); #1;
    op_valid = 1'b0;

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("drain", q.size(), 0);
    repeat (3) begin @(posedge clk); #1; end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
